// File: rtl/sequence_tx.sv
// QPSK reference-sequence generator for the inband TX path. Emits the
// co-coefficient symbol sequence as I/Q samples, one per TX strobe.
module sequence_tx #(
    parameter int MAX_LEN = 192,
    parameter int RPT_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             txstrobe,
    input  logic [31:0]      co_0,
    input  logic [31:0]      co_1,
    input  logic [31:0]      co_2,
    input  logic [31:0]      co_3,
    input  logic [31:0]      co_4,
    input  logic [31:0]      co_5,
    input  logic [31:0]      co_6,
    input  logic [31:0]      co_7,
    input  logic [31:0]      co_8,
    input  logic [31:0]      co_9,
    input  logic [31:0]      co_10,
    input  logic [31:0]      co_11,
    input  logic [7:0]       co_length,
    input  logic             co_valid,
    input  logic [15:0]      amplitude,
    input  logic [RPT_W-1:0] n_repeat,
    input  logic             start,
    input  logic             abort,
    input  logic             ack,
    output logic [15:0]      tx_i,
    output logic [15:0]      tx_q,
    output logic             tx_valid,
    output logic             busy,
    output logic             done,
    output logic             start_err,
    output logic [15:0]      debugbus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [383:0]     co_snap_q, co_snap_d;
    logic [7:0]       len_q, len_d;
    logic [14:0]      amp_q, amp_d;
    logic [7:0]       sym_idx_q, sym_idx_d;
    logic [RPT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [15:0]      tx_i_q, tx_i_d;
    logic [15:0]      tx_q_q, tx_q_d;
    logic             tx_valid_q, tx_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             start_err_q, start_err_d;

    logic [383:0]     co_in;
    logic [1:0]       sym_arr [MAX_LEN];
    logic [1:0]       sym_cur;
    logic [15:0]      pos_a, neg_a, map_i, map_q;
    logic             len_ok;
    logic             unused_amp_msb;

    assign co_in = {co_11, co_10, co_9, co_8, co_7, co_6,
                    co_5, co_4, co_3, co_2, co_1, co_0};
    assign unused_amp_msb = amplitude[15];

    // Symbol k is {co[2k], co[2k+1]} with the even bit as MSB.
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_sym
        assign sym_arr[gi] = {co_snap_q[2*gi], co_snap_q[2*gi+1]};
    end

    assign sym_cur = sym_arr[sym_idx_q];
    assign pos_a   = {1'b0, amp_q};
    assign neg_a   = ~pos_a + 16'd1;
    assign map_i   = sym_cur[1] ? neg_a : pos_a;
    assign map_q   = (sym_cur[1] ^ sym_cur[0]) ? neg_a : pos_a;
    assign len_ok  = (co_length != 8'd0) && (int'(co_length) <= MAX_LEN);

    always_comb begin
        state_d     = state_q;
        co_snap_d   = co_snap_q;
        len_d       = len_q;
        amp_d       = amp_q;
        sym_idx_d   = sym_idx_q;
        rep_cnt_d   = rep_cnt_q;
        tx_i_d      = tx_i_q;
        tx_q_d      = tx_q_q;
        tx_valid_d  = 1'b0;
        done_d      = done_q;
        start_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (txstrobe) begin
                    tx_i_d     = 16'd0;
                    tx_q_d     = 16'd0;
                    tx_valid_d = 1'b1;
                end
                if (start) begin
                    if (co_valid && len_ok) state_d = S_LOAD;
                    else                    start_err_d = 1'b1;
                end
            end
            S_LOAD: begin
                // Outside SEND the stream stays continuous with zero samples.
                tx_valid_d = txstrobe;
                if (txstrobe || abort) begin
                    tx_i_d = 16'd0;
                    tx_q_d = 16'd0;
                end
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    co_snap_d = co_in;
                    len_d     = co_length;
                    amp_d     = amplitude[14:0];
                    sym_idx_d = co_length - 8'd1;
                    rep_cnt_d = n_repeat;
                    state_d   = S_SEND;
                end
            end
            S_SEND: begin
                if (abort) begin
                    state_d    = S_IDLE;
                    tx_i_d     = 16'd0;
                    tx_q_d     = 16'd0;
                    tx_valid_d = txstrobe;
                end else if (txstrobe) begin
                    tx_i_d     = map_i;
                    tx_q_d     = map_q;
                    tx_valid_d = 1'b1;
                    if (sym_idx_q == 8'd0) begin
                        if (rep_cnt_q != '0) begin
                            rep_cnt_d = rep_cnt_q - RPT_W'(1);
                            sym_idx_d = len_q - 8'd1;
                        end else begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        sym_idx_d = sym_idx_q - 8'd1;
                    end
                end
            end
            S_DONE: begin
                if (txstrobe) begin
                    tx_i_d     = 16'd0;
                    tx_q_d     = 16'd0;
                    tx_valid_d = 1'b1;
                end
                // start is deliberately not looked at here, even alongside ack.
                if (ack) begin
                    done_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_LOAD) || (state_d == S_SEND);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            co_snap_q   <= '0;
            len_q       <= '0;
            amp_q       <= '0;
            sym_idx_q   <= '0;
            rep_cnt_q   <= '0;
            tx_i_q      <= '0;
            tx_q_q      <= '0;
            tx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            start_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            co_snap_q   <= co_snap_d;
            len_q       <= len_d;
            amp_q       <= amp_d;
            sym_idx_q   <= sym_idx_d;
            rep_cnt_q   <= rep_cnt_d;
            tx_i_q      <= tx_i_d;
            tx_q_q      <= tx_q_d;
            tx_valid_q  <= tx_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            start_err_q <= start_err_d;
        end
    end

    assign tx_i      = tx_i_q;
    assign tx_q      = tx_q_q;
    assign tx_valid  = tx_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign start_err = start_err_q;
    assign debugbus  = {state_q, busy_q, done_q, tx_valid_q, co_valid,
                        rep_cnt_q[1:0], sym_idx_q};

endmodule

// File: tb/tb_sequence_tx.sv
// Directed bench for sequence_tx: sequence content, repeats, rejected starts,
// snapshot, abort, reset and ack/start collision.
module tb_sequence_tx;

    logic        clk = 1'b0;
    logic        reset, txstrobe, co_valid, start, abort, ack;
    logic [31:0] co_w [12];
    logic [7:0]  co_length;
    logic [15:0] amplitude;
    logic [3:0]  n_repeat;
    logic [15:0] tx_i, tx_q, debugbus;
    logic        tx_valid, busy, done, start_err;

    int checks   = 0;
    int failures = 0;

    localparam logic [15:0] PA = 16'd1000;
    localparam logic [15:0] NA = 16'hFC18;   // -1000
    localparam logic [15:0] PM = 16'h7FFF;   // +32767
    localparam logic [15:0] NM = 16'h8001;   // -32767

    sequence_tx dut (
        .clk(clk), .reset(reset), .txstrobe(txstrobe),
        .co_0(co_w[0]), .co_1(co_w[1]), .co_2(co_w[2]), .co_3(co_w[3]),
        .co_4(co_w[4]), .co_5(co_w[5]), .co_6(co_w[6]), .co_7(co_w[7]),
        .co_8(co_w[8]), .co_9(co_w[9]), .co_10(co_w[10]), .co_11(co_w[11]),
        .co_length(co_length), .co_valid(co_valid), .amplitude(amplitude),
        .n_repeat(n_repeat), .start(start), .abort(abort), .ack(ack),
        .tx_i(tx_i), .tx_q(tx_q), .tx_valid(tx_valid), .busy(busy),
        .done(done), .start_err(start_err), .debugbus(debugbus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Strobe for one cycle, check the sample one clock later and the pulse width;
    // strobes are 4 clocks apart.
    task automatic strobe_expect(input string tag, input logic [15:0] ei, input logic [15:0] eq);
        @(negedge clk); txstrobe = 1'b1;
        @(negedge clk); txstrobe = 1'b0;
        $display("txn %s i=%0d q=%0d valid=%0b done=%0b", tag,
                 $signed(tx_i), $signed(tx_q), tx_valid, done);
        chk({tag, "_valid"}, 16'(tx_valid), 16'd1);
        chk({tag, "_i"}, tx_i, ei);
        chk({tag, "_q"}, tx_q, eq);
        @(negedge clk);
        chk({tag, "_pulse"}, 16'(tx_valid), 16'd0);
        @(negedge clk);
    endtask

    task automatic start_burst(input string tag);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        $display("txn %s start busy=%0b", tag, busy);
        chk({tag, "_busy"}, 16'(busy), 16'd1);
        chk({tag, "_load"}, 16'(debugbus[15:14]), 16'd1);
    endtask

    task automatic ack_done(input string tag);
        @(negedge clk); ack = 1'b1;
        @(negedge clk); ack = 1'b0;
        $display("txn %s ack done=%0b", tag, done);
        chk({tag, "_done_clr"}, 16'(done), 16'd0);
        chk({tag, "_idle"}, 16'(debugbus[15:14]), 16'd0);
    endtask

    task automatic reject_start(input string tag);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        $display("txn %s start_err=%0b busy=%0b", tag, start_err, busy);
        chk({tag, "_err"}, 16'(start_err), 16'd1);
        chk({tag, "_busy"}, 16'(busy), 16'd0);
        @(negedge clk);
        chk({tag, "_err_pulse"}, 16'(start_err), 16'd0);
        chk({tag, "_busy2"}, 16'(busy), 16'd0);
    endtask

    initial begin
        logic [15:0] bi [4];
        logic [15:0] bq [4];
        logic [15:0] ri [4];
        logic [15:0] rq [4];

        reset = 1'b1; txstrobe = 1'b0; co_valid = 1'b0; start = 1'b0;
        abort = 1'b0; ack = 1'b0; co_length = 8'd0; amplitude = 16'd0;
        n_repeat = 4'd0;
        for (int i = 0; i < 12; i++) co_w[i] = 32'd0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx_i", tx_i, 16'd0);
        chk("rst_tx_q", tx_q, 16'd0);
        chk("rst_valid", 16'(tx_valid), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_err", 16'(start_err), 16'd0);
        chk("rst_debug", debugbus, 16'd0);
        reset = 1'b0;

        // Basic: co_0=0x27 gives symbols 3..0 = 00,01,10,11 with {co[2k],co[2k+1]}
        co_w[0] = 32'h00000027; co_length = 8'd4; amplitude = 16'd1000;
        co_valid = 1'b1; n_repeat = 4'd0;
        bi[0] = PA; bq[0] = PA; bi[1] = PA; bq[1] = NA;
        bi[2] = NA; bq[2] = NA; bi[3] = NA; bq[3] = PA;
        start_burst("basic");
        for (int s = 0; s < 4; s++) strobe_expect($sformatf("basic%0d", s), bi[s], bq[s]);
        chk("basic_done", 16'(done), 16'd1);
        chk("basic_busy_end", 16'(busy), 16'd0);
        strobe_expect("basic_done_idle", 16'd0, 16'd0);
        chk("basic_done_held", 16'(done), 16'd1);
        ack_done("basic");

        // Repeat: co_0=0x1B gives symbols 3..0 = 00,10,01,11
        co_w[0] = 32'h0000001B; n_repeat = 4'd2;
        ri[0] = PA; rq[0] = PA; ri[1] = NA; rq[1] = NA;
        ri[2] = PA; rq[2] = NA; ri[3] = NA; rq[3] = PA;
        start_burst("rpt");
        for (int r = 0; r < 3; r++) begin
            for (int s = 0; s < 4; s++) begin
                strobe_expect($sformatf("rpt%0d_%0d", r, s), ri[s], rq[s]);
                if (!(r == 2 && s == 3)) chk($sformatf("rpt%0d_%0d_nodone", r, s), 16'(done), 16'd0);
            end
        end
        chk("rpt_done", 16'(done), 16'd1);
        ack_done("rpt");
        n_repeat = 4'd0;

        // Rejected starts
        co_length = 8'd0;   reject_start("rej_len0");
        co_length = 8'd193; reject_start("rej_len193");
        co_length = 8'd4; co_valid = 1'b0; reject_start("rej_invalid");
        co_valid = 1'b1;

        // Full length with a mid-burst coefficient change
        for (int i = 0; i < 12; i++) co_w[i] = 32'hFFFFFFFF;
        co_length = 8'd192; amplitude = 16'hFFFF;
        start_burst("full");
        for (int k = 0; k < 192; k++) begin
            if (k == 50) co_w[0] = 32'h00000000;
            strobe_expect($sformatf("full%0d", k), NM, PM);
        end
        chk("full_done", 16'(done), 16'd1);
        ack_done("full");

        // Abort: symbols 9..6 = 00,01,10,11 from co_0=0x27000
        for (int i = 0; i < 12; i++) co_w[i] = 32'd0;
        co_w[0] = 32'h00027000; co_length = 8'd10; amplitude = 16'd1000;
        start_burst("abt");
        strobe_expect("abt0", PA, PA);
        strobe_expect("abt1", PA, NA);
        strobe_expect("abt2", NA, NA);
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        $display("txn abort busy=%0b done=%0b", busy, done);
        chk("abt_busy", 16'(busy), 16'd0);
        chk("abt_done", 16'(done), 16'd0);
        chk("abt_tx_i", tx_i, 16'd0);
        chk("abt_tx_q", tx_q, 16'd0);
        chk("abt_idle", 16'(debugbus[15:14]), 16'd0);
        strobe_expect("abt_post", 16'd0, 16'd0);
        start_burst("abt_re");
        strobe_expect("abt_re0", PA, PA);
        strobe_expect("abt_re1", PA, NA);
        strobe_expect("abt_re2", NA, NA);
        strobe_expect("abt_re3", NA, PA);

        // Reset during SEND
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        $display("txn reset_mid busy=%0b", busy);
        chk("rmid_tx_i", tx_i, 16'd0);
        chk("rmid_tx_q", tx_q, 16'd0);
        chk("rmid_valid", 16'(tx_valid), 16'd0);
        chk("rmid_busy", 16'(busy), 16'd0);
        chk("rmid_done", 16'(done), 16'd0);
        chk("rmid_debug", debugbus, 16'h0400);
        reset = 1'b0;
        @(negedge clk);
        chk("rmid_stay_idle", 16'(busy), 16'd0);

        // ack and start together in DONE: back to IDLE, no new burst
        co_length = 8'd1;
        start_burst("col");
        strobe_expect("col0", PA, PA);
        chk("col_done", 16'(done), 16'd1);
        @(negedge clk); ack = 1'b1; start = 1'b1;
        @(negedge clk); ack = 1'b0; start = 1'b0;
        $display("txn ack_start done=%0b busy=%0b", done, busy);
        chk("col_done_clr", 16'(done), 16'd0);
        chk("col_idle", 16'(debugbus[15:14]), 16'd0);
        chk("col_busy", 16'(busy), 16'd0);
        @(negedge clk);
        chk("col_busy2", 16'(busy), 16'd0);
        chk("col_idle2", 16'(debugbus[15:14]), 16'd0);
        strobe_expect("col_idle_out", 16'd0, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
